// File: rtl/rr_arbiter.sv
// Eight-way round-robin arbiter with a bounded hold time per grant.
// Each release costs one idle cycle before the next grant is issued.
module rr_arbiter #(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state;
   logic [2:0] ptr;
   logic [7:0] hold_cnt;
   logic [2:0] sel;

   // First set bit at or after p, wrapping; the smallest offset wins.
   function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] idx;
      pick = p;
      for (int k = 7; k >= 0; k--) begin
         idx = p + 3'(k);
         if (r[idx]) pick = idx;
      end
   endfunction

   always_comb sel = pick(req, ptr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 3'd0;
         hold_cnt  <= 8'd0;
         gnt       <= 8'd0;
         gnt_id    <= 3'd0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt       <= 8'd1 << sel;
                  gnt_id    <= sel;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= 8'd1;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (!req[gnt_id] || hold_cnt >= 8'(MAX_HOLD)) begin
                  // Release path; timeout flags only a forced release.
                  timeout   <= req[gnt_id];
                  ptr       <= gnt_id + 3'd1;
                  gnt       <= 8'd0;
                  gnt_id    <= 3'd0;
                  gnt_valid <= 1'b0;
                  hold_cnt  <= 8'd0;
                  state     <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios plus random traffic against a
// behavioural model of the arbitration rules.
module tb_rr_arbiter;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'd0;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   // Model state: owner = -1 when nobody holds the resource.
   int   owner = -1;
   int   mptr  = 0;
   int   mcnt  = 0;
   logic mto   = 1'b0;

   rr_arbiter #(.MAX_HOLD(MAXH)) dut (
      .clk(clk), .rst(rst), .req(req),
      .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [7:0] r, input logic rs);
      if (rs) begin
         owner = -1; mptr = 0; mcnt = 0; mto = 1'b0;
      end else if (owner < 0) begin
         mto = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (owner < 0 && r[(mptr + k) % 8]) begin
               owner = (mptr + k) % 8;
               mcnt  = 1;
            end
         end
      end else if (!r[owner] || mcnt == MAXH) begin
         mto   = r[owner];
         mptr  = (owner + 1) % 8;
         owner = -1;
         mcnt  = 0;
      end else begin
         mcnt++;
         mto = 1'b0;
      end
   endtask

   task automatic step(input logic [7:0] r, input logic rs);
      logic [7:0] eg;
      @(negedge clk);
      req = r;
      rst = rs;
      @(posedge clk);
      model(r, rs);
      #1;
      eg = (owner < 0) ? 8'd0 : (8'd1 << owner);
      chk("gnt", 32'(gnt), 32'(eg));
      chk("gnt_valid", 32'(gnt_valid), 32'(owner >= 0));
      chk("timeout", 32'(timeout), 32'(mto));
      chk("onehot", 32'($onehot0(gnt)), 32'd1);
      if (owner >= 0) chk("gnt_id", 32'(gnt_id), 32'(owner));
   endtask

   initial begin
      int seq[$];
      logic [7:0] r;
      logic       pv;
      int         held;
      int         tocnt;
      logic       seen_to;

      step(8'h00, 1'b1);
      step(8'h00, 1'b1);
      chk("reset_gnt", 32'(gnt), 32'd0);
      chk("reset_gnt_id", 32'(gnt_id), 32'd0);

      // All quiet after reset.
      for (int i = 0; i < 5; i++) step(8'h00, 1'b0);

      // Two requesters: 2 first, then 5 after one idle cycle.
      step(8'h24, 1'b0);
      chk("first_gnt", 32'(gnt), 32'h04);
      chk("first_id", 32'(gnt_id), 32'd2);
      step(8'h20, 1'b0);
      chk("release_idle", 32'(gnt), 32'd0);
      step(8'h20, 1'b0);
      chk("second_gnt", 32'(gnt), 32'h20);
      chk("second_id", 32'(gnt_id), 32'd5);
      step(8'h00, 1'b0);

      // Full rotation, each holder releasing after three granted cycles.
      step(8'h00, 1'b1);
      pv = 1'b0;
      for (int i = 0; i < 40; i++) begin
         r = 8'hFF;
         if (owner >= 0 && mcnt >= 3) r[owner] = 1'b0;
         step(r, 1'b0);
         if (gnt_valid && !pv) seq.push_back(int'(gnt_id));
         pv = gnt_valid;
      end
      chk("rotation_len", 32'(seq.size() >= 9), 32'd1);
      for (int i = 0; i < 9 && i < seq.size(); i++)
         chk("rotation_order", 32'(seq[i]), 32'(i % 8));

      // Continuous request forces release after MAXH cycles.
      step(8'h00, 1'b1);
      held = 0; tocnt = 0; seen_to = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(8'h08, 1'b0);
         if (timeout) begin
            tocnt++;
            if (!seen_to) chk("forced_hold_len", 32'(held), 32'(MAXH));
            seen_to = 1'b1;
         end
         if (gnt_valid && !seen_to) held++;
      end
      chk("timeout_seen", 32'(tocnt >= 1), 32'd1);

      // Pointer wraps from 7 back to 0.
      step(8'h00, 1'b1);
      step(8'h80, 1'b0);
      chk("grant7", 32'(gnt_id), 32'd7);
      step(8'h01, 1'b0);
      step(8'h81, 1'b0);
      chk("wrap_id", 32'(gnt_id), 32'd0);
      chk("wrap_valid", 32'(gnt_valid), 32'd1);

      // Reset mid-grant restarts priority at requester 0.
      step(8'h00, 1'b1);
      step(8'h20, 1'b0);
      step(8'h02, 1'b0);
      step(8'h00, 1'b1);
      step(8'h00, 1'b0);
      step(8'h20, 1'b0);
      chk("pre_rst_id", 32'(gnt_id), 32'd5);
      step(8'h20, 1'b1);
      chk("rst_drop", 32'(gnt), 32'd0);
      step(8'h22, 1'b0);
      chk("post_rst_id", 32'(gnt_id), 32'd1);

      // Random traffic, holders tend to keep their bit, rare resets.
      for (int i = 0; i < 400; i++) begin
         r = 8'($urandom);
         if (owner >= 0 && $urandom_range(3) != 0) r[owner] = 1'b1;
         step(r, $urandom_range(60) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 15, maximum consecutive cycles one requester may hold the grant (legal range 2..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  8  request vector; bit i = requester i wants the shared resource.
REQ-005 gnt  output  8  one-hot grant vector, registered.
REQ-006 gnt_id  output  3  binary index of the granted requester, registered; valid only while gnt_valid=1.
REQ-007 gnt_valid  output  1  high while a grant is active (gnt != 0), registered.
REQ-008 timeout  output  1  one-cycle pulse on a forced release after MAX_HOLD cycles, registered.

Function
REQ-009 The block shall implement a two-state FSM, IDLE and GRANT, with all outputs driven from registers.
REQ-010 The block shall hold a 3-bit round-robin pointer ptr giving the highest-priority requester for the next arbitration.
REQ-011 IDLE, req==0: stay in IDLE; gnt=0, gnt_id=0, gnt_valid=0.
REQ-012 IDLE, req!=0: select the first set bit scanning ptr, ptr+1, ... ptr+7 (mod 8).
REQ-013 IDLE grant cycle: load gnt=1<<idx, gnt_id=idx, gnt_valid=1, hold_cnt=1; go to GRANT; outputs visible the cycle after req is sampled (latency 1).
REQ-014 GRANT, req[gnt_id]=1 and hold_cnt<MAX_HOLD: keep the grant unchanged; hold_cnt+=1.
REQ-015 GRANT, req[gnt_id]=0 (normal release): next cycle gnt=0, gnt_valid=0, ptr=gnt_id+1 mod 8; go to IDLE.
REQ-016 GRANT, req[gnt_id]=1 and hold_cnt==MAX_HOLD (forced release): same as REQ-015; timeout=1 for that one cycle.
REQ-017 Every release shall be followed by exactly one IDLE cycle with gnt=0 before any new grant.
REQ-018 Changes to other req bits during GRANT shall not affect the active grant.
REQ-019 gnt shall never have more than one bit set.
REQ-020 ptr wrap-around: a release of gnt_id=7 shall set ptr=0.
REQ-021 hold_cnt shall be 8 bits wide and shall not increment past MAX_HOLD.
REQ-022 Fairness: with all 8 requests held high continuously, grants shall rotate 0,1,...,7,0 with no requester granted twice before every other requester has been granted once.

Reset
REQ-023 rst=1 at a rising edge shall force IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, overriding all other conditions.
REQ-024 Reset asserted during GRANT shall drop the grant on the next edge; the first grant after rst deasserts starts priority from requester 0.

Verification
REQ-025 Reset then req=8'b0000_0000 for 5 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
REQ-026 req=8'b0010_0100 from reset -> next cycle gnt=8'b0000_0100, gnt_id=2; drop req[2] -> gnt=0 for one cycle, then gnt=8'b0010_0000, gnt_id=5.
REQ-027 req=8'hFF held, each holder drops its request 3 cycles after being granted -> gnt_id sequence 0,1,...,7,0, each grant separated by one idle cycle.
REQ-028 MAX_HOLD=4, req=8'b0000_1000 held -> gnt_id=3 for exactly 4 cycles, timeout pulse on the release cycle, 1 idle cycle, then gnt_id=3 again.
REQ-029 Grant of requester 7 released with req=8'b1000_0001 -> next grant is gnt_id=0 (pointer wrap).
REQ-030 rst pulsed for 1 cycle mid-GRANT with gnt_id=5 -> gnt=0 on the next edge; with req=8'b0010_0010 afterwards -> first grant is gnt_id=1.
